// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types and helpers for the instruction fetch buffer and its FIFOs.
package instr_fetch_buffer_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] instr;
    } fetch_entry_t;

    // Occupancy counters must be able to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_buffer_sync_fifo.sv
// Single-clock FIFO with registered storage; push on full is accepted only
// when a pop frees the head slot in the same cycle.
module sync_fifo
    import instr_fetch_buffer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch buffer between PC register and decode: issues in-order memory reads under
// a credit limit and queues returned words with their PC; flush drops stale fetches.
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int CW = cnt_w(DEPTH);
    localparam int EW = ADDR_W + DATA_W;

    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     tag_count;
    logic [CW-1:0]     buf_count;
    logic [CW:0]       credit_used;
    logic              tag_full;
    logic              tag_empty;
    logic              buf_full;
    logic              buf_empty;
    logic [ADDR_W-1:0] tag_head;
    logic [EW-1:0]     buf_head;
    logic              accept;
    logic              rsp;
    logic              rsp_keep;
    logic              pop;

    // Every in-flight request is guaranteed a buffer slot, so responses never stall.
    assign credit_used = {1'b0, outstanding} + {1'b0, buf_count} + {1'b0, drop};
    assign pc_ready    = ~flush & (credit_used < (CW+1)'(DEPTH));
    assign accept      = pc_valid & pc_ready;
    assign mem_req     = accept;
    assign mem_addr    = pc;

    // A response with nothing outstanding has no tag and is ignored.
    assign rsp      = mem_rvalid & ~tag_empty;
    assign rsp_keep = rsp & (drop == '0);
    assign pop      = instr_valid & instr_ready & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
            drop        <= '0;
        end else if (flush) begin
            // Everything still owed by memory after this cycle must be discarded.
            outstanding <= '0;
            drop        <= drop + outstanding - CW'(rsp);
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(rsp_keep);
            drop        <= drop - CW'(rsp & (drop != '0));
        end
    end

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .push  (accept),
        .pop   (rsp),
        .wdata (pc),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_buf (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (rsp_keep),
        .pop   (pop),
        .wdata ({tag_head, mem_rdata}),
        .rdata (buf_head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count)
    );

    assign instr_valid = ~buf_empty;
    assign instr       = instr_valid ? buf_head[DATA_W-1:0] : '0;
    assign instr_pc    = instr_valid ? buf_head[EW-1 -: ADDR_W] : '0;

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(mem_rvalid && outstanding == '0 && drop == '0));

    a_tag_consistent: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, tag_count} == {1'b0, outstanding} + {1'b0, drop}));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !((accept && tag_full) || (rsp_keep && buf_full && !pop)));

endmodule
